// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 byte mux: walks enabled channels in ascending order,
// captures each mux byte and streams it out over valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned NCH = 8,
  parameter int unsigned W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [NCH-1:0] en_mask,
  input  logic [W-1:0]   mux_o,
  output logic           C2,
  output logic           C1,
  output logic           C0,
  output logic [W-1:0]   dout,
  output logic [2:0]     dout_ch,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW  = 3;
  localparam int unsigned CW1 = CW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEL  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state, state_n;
  logic [NCH-1:0] mask, mask_n;
  logic [CW-1:0]  ch, ch_n;
  logic [W-1:0]   dout_n;
  logic [CW-1:0]  dout_ch_n;
  logic           dout_valid_n;
  logic [CW:0]    first_c, next_c;

  // Lowest set bit of m at index >= lo; MSB of the result flags a hit.
  function automatic logic [CW:0] find_from(input logic [NCH-1:0] m, input logic [CW:0] lo);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (CW1'(i) >= lo)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  always_comb first_c = find_from(en_mask, '0);
  always_comb next_c  = find_from(mask, CW1'(ch) + CW1'(1));

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    mask_n       = mask;
    ch_n         = ch;
    dout_n       = dout;
    dout_ch_n    = dout_ch;
    dout_valid_n = dout_valid;
    case (state)
      S_IDLE: begin
        if (start) begin
          mask_n = en_mask;
          if (first_c[CW]) begin
            ch_n    = first_c[CW-1:0];
            state_n = S_SEL;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_SEL: begin
        // mux has seen the current select for a full cycle, capture is safe
        dout_n       = mux_o;
        dout_ch_n    = ch;
        dout_valid_n = 1'b1;
        state_n      = S_OUT;
      end
      S_OUT: begin
        if (dout_ready) begin
          dout_valid_n = 1'b0;
          if (next_c[CW]) begin
            ch_n    = next_c[CW-1:0];
            state_n = S_SEL;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        ch_n    = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mask       <= '0;
      ch         <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      mask       <= mask_n;
      ch         <= ch_n;
      dout       <= dout_n;
      dout_ch    <= dout_ch_n;
      dout_valid <= dout_valid_n;
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

  assign {C2, C1, C0} = ch;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with a behavioural 8:1 mux returning 8'h10+sel.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] en_mask;
  logic [7:0] mux_o;
  logic       C2, C1, C0;
  logic [7:0] dout;
  logic [2:0] dout_ch;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;
  logic [2:0] sel;

  int n_cmp = 0;
  int n_bad = 0;

  mux_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .en_mask(en_mask), .mux_o(mux_o),
    .C2(C2), .C1(C1), .C0(C0), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign sel   = {C2, C1, C0};
  assign mux_o = 8'h10 + {5'b0, sel};

  typedef struct {
    logic       start;
    logic [7:0] mask;
    logic       ready;
    logic [2:0] e_sel;
    logic       e_valid;
    logic [7:0] e_dout;
    logic [2:0] e_ch;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic s, input logic [7:0] m, input logic r,
                              input logic [2:0] es, input logic ev, input logic [7:0] ed,
                              input logic [2:0] ec, input logic eb, input logic edn);
    vec_t v;
    v.start = s; v.mask = m; v.ready = r; v.e_sel = es; v.e_valid = ev;
    v.e_dout = ed; v.e_ch = ec; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [2:0] es, input logic ev,
                         input logic [7:0] ed, input logic [2:0] ec,
                         input logic eb, input logic edn);
    chk({nm, ".sel"},   32'(sel),        32'(es));
    chk({nm, ".valid"}, 32'(dout_valid), 32'(ev));
    chk({nm, ".busy"},  32'(busy),       32'(eb));
    chk({nm, ".done"},  32'(done),       32'(edn));
    if (ev) begin
      chk({nm, ".dout"},    32'(dout),    32'(ed));
      chk({nm, ".dout_ch"}, 32'(dout_ch), 32'(ec));
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, k;

    // sparse mask A4: channels 2,5,7
    tbl[0]  = mk(1'b1, 8'hA4, 1'b1, 3'd2, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 8'hA4, 1'b1, 3'd2, 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 8'hA4, 1'b1, 3'd5, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 8'hA4, 1'b1, 3'd5, 1'b1, 8'h15, 3'd5, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 8'hA4, 1'b1, 3'd7, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 8'hA4, 1'b1, 3'd7, 1'b1, 8'h17, 3'd7, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 8'hA4, 1'b1, 3'd7, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 8'hA4, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 8'hA4, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // zero mask: straight to DONE
    tbl[9]  = mk(1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // start/mask changes during a scan of mask 03 are ignored
    tbl[12] = mk(1'b1, 8'h03, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 8'h03, 1'b1, 3'd0, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 8'h00, 1'b1, 3'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 8'hFF, 1'b1, 3'd1, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 8'hFF, 1'b1, 3'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    reset = 1'b1; start = 1'b0; en_mask = 8'h00; dout_ready = 1'b1;
    step();
    step();
    chk_out("reset", 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("reset.dout",    32'(dout),    32'h0);
    chk("reset.dout_ch", 32'(dout_ch), 32'h0);
    reset = 1'b0;
    step();

    // full scan, all channels enabled, ready tied high
    start = 1'b1; en_mask = 8'hFF;
    step();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; k = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && !dout_valid && !done) chk("full.sel", 32'(sel), 32'(k));
      if (dout_valid) begin
        chk("full.dout",    32'(dout),    32'(8'h10 + 8'(k)));
        chk("full.dout_ch", 32'(dout_ch), 32'(k));
        k++;
      end
      step();
    end
    chk("full.transfers", 32'(k), 32'd8);
    chk("full.busy_cycles", 32'(busy_cnt), 32'd17);
    chk("full.done_pulses", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; en_mask = tbl[i].mask; dout_ready = tbl[i].ready;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_valid, tbl[i].e_dout,
              tbl[i].e_ch, tbl[i].e_busy, tbl[i].e_done);
    end
    start = 1'b0;

    // backpressure on channel 0 of mask 03
    dout_ready = 1'b0; start = 1'b1; en_mask = 8'h03;
    step();
    start = 1'b0;
    chk_out("bp.sel0", 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    step();
    chk_out("bp.out0", 3'd0, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp.stall%0d", i), 3'd0, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0);
    end
    dout_ready = 1'b1;
    step();
    chk_out("bp.sel1", 3'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    step();
    chk_out("bp.out1", 3'd1, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0);
    step();
    chk_out("bp.done", 3'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    step();
    chk_out("bp.idle", 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // reset while holding channel 3 in OUT
    dout_ready = 1'b0; start = 1'b1; en_mask = 8'h08;
    step();
    start = 1'b0;
    step();
    chk_out("rst.out3", 3'd3, 1'b1, 8'h13, 3'd3, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("rst.abort", 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("rst.dout",    32'(dout),    32'h0);
    chk("rst.dout_ch", 32'(dout_ch), 32'h0);
    step();
    chk_out("rst.nodone", 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    dout_ready = 1'b1; start = 1'b1; en_mask = 8'h08;
    step();
    start = 1'b0;
    chk_out("rst.sel3", 3'd3, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    step();
    chk_out("rst.out3b", 3'd3, 1'b1, 8'h13, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("rst.done", 3'd3, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    step();
    chk_out("rst.idle", 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly in front of the 8:1 byte mux.
- Drives the mux select lines C2/C1/C0 and captures the mux's 8-bit output O on its mux_o input.
- Streams the captured bytes out one per enabled channel over a valid/ready interface.
- One scan is triggered by a start pulse and covers channels 0..7 in ascending order, skipping channels masked off.

Parameters:
NCH, 8, number of mux channels (fixed 8; select is 3 bits)
W, 8, data width of mux output and stream output

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one scan; sampled only in IDLE
en_mask  input  8  channel enable, bit i = channel i; sampled when start is accepted
mux_o  input  8  byte from mux output O (combinational from C2..C0)
C2  output  1  mux select bit 2
C1  output  1  mux select bit 1
C0  output  1  mux select bit 0
dout  output  8  captured channel byte
dout_ch  output  3  channel index of dout
dout_valid  output  1  dout/dout_ch valid
dout_ready  input  1  downstream accepts the current dout
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a scan finishes

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mask register=0; {C2,C1,C0}=0; dout=0; dout_ch=0; dout_valid=0; busy=0; done=0. Reset asserted mid-scan aborts immediately with no done pulse, and any pending dout is dropped.
- Select outputs {C2,C1,C0} are registered, equal the current channel register, and hold their value except in SEL transitions. They are 0 in IDLE.
- States: IDLE, SEL, OUT, DONE.
- IDLE: start=1 latches en_mask.
  - Mask nonzero: channel register = lowest set bit; go to SEL.
  - Mask zero: go to DONE, with no output.
  - start=0: stay in IDLE.
- SEL: the mux has settled for one full cycle on the current select. At the edge, dout<=mux_o, dout_ch<=channel, dout_valid<=1; go to OUT. Latency is 2 cycles from start acceptance to dout_valid.
- OUT: dout_valid held high; dout and dout_ch are stable until transfer. Transfer occurs on the edge where dout_valid&&dout_ready. At transfer, dout_valid<=0, then:
  - If a higher-numbered enabled channel remains: channel register = next set bit above current; go to SEL.
  - Otherwise: go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE. busy stays 1 in DONE.
- start while busy (SEL/OUT/DONE) is ignored and not queued. Changes to en_mask mid-scan have no effect.
- Channel advance never wraps: the scan ends after the highest enabled channel. Channel 7 is the last possible.
- Minimum scan with all 8 enabled and dout_ready tied high: 1 (accept) + 8×2 + 1 (DONE) cycles. busy is high 17 cycles.
- dout_ready asserted with dout_valid=0 has no effect.
- Implement with a 3-bit channel register and a priority "next set bit above index" function; no combinational path from mux_o to any output.

Test Plan:
- Reset then idle: hold reset 2 cycles → all outputs 0, busy=0. Pulse start with en_mask=8'hFF; bench mux model returns 8'h10+sel. With dout_ready=1: 8 transfers with dout=10..17 and dout_ch=0..7, done pulse once, busy high 17 cycles.
- Sparse mask: en_mask=8'b1010_0100 → transfers only for channels 2, 5, 7 with dout=12, 15, 17. {C2,C1,C0} is 2, 5, 7 in the respective SEL cycles. Exactly one done pulse follows.
- Backpressure: en_mask=8'h03, dout_ready low for 5 cycles in OUT for channel 0 → dout_valid stays 1 and dout stays 10 for the whole stall. Transfer happens on the ready cycle, then channel 1 follows.
- Zero mask: start with en_mask=0 → done pulse 1 cycle after acceptance, no dout_valid, busy high 1 cycle.
- Start and mask changes during scan: a second start pulse and en_mask=0 applied in OUT → neither affects the current scan. No second scan occurs afterward.
- Reset mid-scan: assert reset in OUT for channel 3 → next cycle all outputs 0, state IDLE, no done pulse. A fresh start then works normally.
